// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one shared single-port memory with a fixed access
// latency. Define ARB_RR_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  // Instruction-fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  // Data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  // Shared memory bus
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    StIdle,
    StSrvIf,
    StSrvD
  } state_e;

  localparam logic [3:0] LatCnt = 4'(MEM_LAT);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          if_gnt_q, if_gnt_d;
  logic          d_gnt_q, d_gnt_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          pick_d;

`ifdef ARB_RR_EN
  // Set when the data port took the most recent grant; resets to fetch so data wins the first tie.
  logic last_d_q, last_d_d;

  assign pick_d = d_req && (!if_req || !last_d_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ARB_RR_EN
    last_d_d    = last_d_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          state_d     = pick_d ? StSrvD : StSrvIf;
          cnt_d       = 4'd1;
          if_gnt_d    = !pick_d;
          d_gnt_d     = pick_d;
          // The mem_* registers double as the latched request for the whole service window.
          mem_en_d    = 1'b1;
          mem_we_d    = pick_d && d_we;
          mem_addr_d  = pick_d ? d_addr : if_addr;
          mem_wdata_d = pick_d ? d_wdata : '0;
`ifdef ARB_RR_EN
          last_d_d    = pick_d;
`endif
        end
      end

      StSrvIf, StSrvD: begin
        if (cnt_q == LatCnt) begin
          state_d     = StIdle;
          cnt_d       = 4'd0;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (state_q == StSrvIf) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: drivers queue expected transactions, a negedge
// monitor checks grants, memory bus, latency and read data against a cycle-count reference.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 3;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 32;
  localparam int          Bound   = 200;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk, rst;
  logic          if_req, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory answers correctly only in the MEM_LAT-th consecutive enabled cycle.
  int en_run;
  always @(posedge clk or negedge rst) begin
    if (!rst) en_run <= 0;
    else      en_run <= mem_en ? en_run + 1 : 0;
  end
  assign mem_rdata = (mem_en && en_run == int'(MEM_LAT) - 1) ? rd_fn(mem_addr)
                                                              : ~rd_fn(mem_addr);

  // Scoreboard queues, pushed by the drivers at issue time.
  logic [AW-1:0] if_q[$];
  txn_t          d_q[$];
  logic          glog[$];

  function automatic logic arb(input logic rq_if, input logic rq_d, input logic last_d);
`ifdef ARB_RR_EN
    if (rq_if && rq_d) return !last_d;
`endif
    return rq_d;
  endfunction

  // Reference: one service window of MEM_LAT cycles after each accept, valid in the next cycle.
  int            cyc;
  int            busy_until;
  logic          cur_d, last_d_m, p_if, p_d, acc, win_d, busy_exp;
  logic [DW-1:0] if_rd_m, d_rd_m;

  initial begin
    busy_until = -1000;
    cur_d      = 1'b0;
    last_d_m   = 1'b0;
    win_d      = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_if_gnt", if_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
      chk("rst_if_valid", if_valid, 0); chk("rst_d_valid", d_valid, 0);
      chk("rst_busy", busy, 0);         chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);     chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
      if_q.delete(); d_q.delete(); glog.delete();
      busy_until = -1000; cyc = 0; cur_d = 1'b0; last_d_m = 1'b0;
      if_rd_m = '0; d_rd_m = '0;
      p_if = if_req; p_d = d_req;
    end else begin
      cyc++;
      acc = 1'b0;
      if ((cyc - 1 > busy_until) && (p_if || p_d)) begin
        win_d      = arb(p_if, p_d, last_d_m);
        last_d_m   = win_d;
        cur_d      = win_d;
        busy_until = cyc + int'(MEM_LAT) - 1;
        acc        = 1'b1;
        glog.push_back(win_d);
      end
      chk("if_gnt", if_gnt, acc && !win_d);
      chk("d_gnt", d_gnt, acc && win_d);
      busy_exp = (cyc <= busy_until);
      chk("busy", busy, busy_exp);
      chk("mem_en", mem_en, busy_exp);
      if (busy_exp) begin
        if (cur_d) begin
          chk("d_q_in_service", d_q.size() != 0, 1'b1);
          if (d_q.size() != 0) begin
            chk("mem_addr_d", mem_addr, d_q[0].addr);
            chk("mem_we_d", mem_we, d_q[0].we);
            chk("mem_wdata_d", mem_wdata, d_q[0].wdata);
          end
        end else begin
          chk("if_q_in_service", if_q.size() != 0, 1'b1);
          if (if_q.size() != 0) begin
            chk("mem_addr_if", mem_addr, if_q[0]);
            chk("mem_we_if", mem_we, 1'b0);
          end
        end
      end else begin
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
      end
      chk("if_valid", if_valid, (cyc == busy_until + 1) && !cur_d);
      chk("d_valid", d_valid, (cyc == busy_until + 1) && cur_d);
      if (if_valid) begin
        chk("if_valid_has_txn", if_q.size() != 0, 1'b1);
        if (if_q.size() != 0) if_rd_m = rd_fn(if_q.pop_front());
      end
      if (d_valid) begin
        chk("d_valid_has_txn", d_q.size() != 0, 1'b1);
        if (d_q.size() != 0) begin
          txn_t t;
          t = d_q.pop_front();
          if (!t.we) d_rd_m = rd_fn(t.addr);
        end
      end
      chk("if_rdata", if_rdata, if_rd_m);
      chk("d_rdata", d_rdata, d_rd_m);
      p_if = if_req; p_d = d_req;
    end
  end

  // Drivers: called at posedge+1; hold the request until the grant, drop it one edge later.
  task automatic fetch_txn(input logic [AW-1:0] a);
    logic got;
    got = 1'b0;
    if_req = 1'b1; if_addr = a;
    if_q.push_back(a);
    for (int c = 0; c < Bound && !got; c++) begin
      @(negedge clk);
      got = if_gnt;
    end
    chk("if_gnt_wait", got, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic got;
    txn_t t;
    got = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    t.we = we; t.addr = a; t.wdata = wd;
    d_q.push_back(t);
    for (int c = 0; c < Bound && !got; c++) begin
      @(negedge clk);
      got = d_gnt;
    end
    chk("d_gnt_wait", got, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && (if_q.size() != 0 || d_q.size() != 0); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_if_q", if_q.size(), 0);
    chk("drain_d_q", d_q.size(), 0);
  endtask

  logic exp_order[4];

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
`ifdef ARB_RR_EN
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
`else
    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
`endif
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // Simultaneous, continuously held requests straight out of reset.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 4; i++) fetch_txn(32'h100 + 32'(i * 4));
      end
      begin
        for (int i = 0; i < 4; i++) data_txn(1'b0, 32'h200 + 32'(i * 4), 32'(i));
      end
    join
    drain();
    chk("tie_log_len", glog.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) chk($sformatf("tie_grant%0d", i), glog[i], exp_order[i]);
    end

    // Random traffic on both ports.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          fetch_txn($urandom & 32'hFFFF_FFFC);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          data_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
        end
      end
    join
    drain();

    // Directed write: d_rdata must keep the last load value.
    @(posedge clk); #1;
    data_txn(1'b1, 32'h20, 32'h55);
    drain();
    chk("write_keeps_rdata", d_rdata, d_rd_m);

    // Reset during the second service cycle of a load.
    @(posedge clk); #1;
    data_txn(1'b0, 32'h40, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_d_valid", d_valid, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    fetch_txn(32'h10);
    drain();
    chk("post_rst_fetch", if_rdata, rd_fn(32'h10));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
